mandel_cmd_tx: RTL and testbench

- UART 8N1 transmitter for the Mandelbrot render-command frame: the sending end of the 13-byte command protocol that the render core's RX8 receiver parses.
- Captures a full parameter set on a start strobe, serializes the 13 bytes LSB-first, then pulses done.
- Use cases: board-to-board render control, loopback drive into the render core's RXD, bench stimulus generation.
- Contains its own baud divider and bit-level shifter; the frame sequencer and the bit transmitter live in one module.

---
 rtl/mandel_cmd_tx.sv | 218 +++++++++++++++++++++
 tb/tb_mandel_cmd_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_cmd_tx.sv
// UART 8N1 sender for the 13-byte Mandelbrot render-command frame, LSB first.
// Define MANDEL_CMD_TX_CKSUM_EN to append a 14th byte holding the XOR of b0..b12.
module mandel_cmd_tx #(
    parameter int CLK_HZ   = 24000000,
    parameter int BAUD     = 115200,
    parameter int GAP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  pix_x,
    input  logic [7:0]  pix_y,
    input  logic [15:0] cxs,
    input  logic [15:0] cys,
    input  logic [15:0] dcx,
    input  logic [15:0] dcy,
    input  logic [15:0] max_iter,
    output logic        txd,
    output logic        busy,
    output logic        done
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int GW  = (GAP_BITS > 2) ? $clog2(GAP_BITS) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'((DIV > 0) ? DIV - 1 : 0);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
`ifdef MANDEL_CMD_TX_CKSUM_EN
    localparam logic [3:0] LAST_BYTE = 4'd13;
`else
    localparam logic [3:0] LAST_BYTE = 4'd12;
`endif

    if (DIV < 2) begin : g_bad_div
        $error("mandel_cmd_tx: CLK_HZ/BAUD must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [3:0]      byte_q, byte_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            done_q, done_d;
    logic            txd_q, txd_d;
    logic [8:0]      pix_x_q, pix_x_d;
    logic [7:0]      pix_y_q, pix_y_d;
    logic [15:0]     cxs_q, cxs_d, cys_q, cys_d, dcx_q, dcx_d, dcy_q, dcy_d;
    logic [15:0]     max_iter_q, max_iter_d;
    logic            baud_tick;
    logic [7:0]      next_byte;

    function automatic logic [7:0] frame_byte(
        input logic [3:0]  idx,
        input logic [8:0]  px,
        input logic [7:0]  py,
        input logic [15:0] cx,
        input logic [15:0] cy,
        input logic [15:0] dx,
        input logic [15:0] dy,
        input logic [15:0] mi
    );
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd0:  b = {7'b0, px[8]};
            4'd1:  b = px[7:0];
            4'd2:  b = py;
            4'd3:  b = cx[15:8];
            4'd4:  b = cx[7:0];
            4'd5:  b = cy[15:8];
            4'd6:  b = cy[7:0];
            4'd7:  b = dx[15:8];
            4'd8:  b = dx[7:0];
            4'd9:  b = dy[15:8];
            4'd10: b = dy[7:0];
            4'd11: b = mi[15:8];
            4'd12: b = mi[7:0];
`ifdef MANDEL_CMD_TX_CKSUM_EN
            4'd13: b = {7'b0, px[8]} ^ px[7:0] ^ py ^ cx[15:8] ^ cx[7:0] ^ cy[15:8] ^ cy[7:0]
                       ^ dx[15:8] ^ dx[7:0] ^ dy[15:8] ^ dy[7:0] ^ mi[15:8] ^ mi[7:0];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign baud_tick = (baud_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        gap_d      = gap_q;
        done_d     = 1'b0;
        pix_x_d    = pix_x_q;
        pix_y_d    = pix_y_q;
        cxs_d      = cxs_q;
        cys_d      = cys_q;
        dcx_d      = dcx_q;
        dcy_d      = dcy_q;
        max_iter_d = max_iter_q;

        // Baud counter free-runs through a frame and sits at zero while idle.
        if (state_q != IDLE) begin
            baud_d = baud_tick ? '0 : baud_q + BW'(1);
        end

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (start) begin
                    state_d    = START;
                    byte_d     = 4'd0;
                    bit_d      = 3'd0;
                    gap_d      = '0;
                    pix_x_d    = pix_x;
                    pix_y_d    = pix_y;
                    cxs_d      = cxs;
                    cys_d      = cys;
                    dcx_d      = dcx;
                    dcy_d      = dcy;
                    max_iter_d = max_iter;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (GAP_BITS == 0) begin
                        state_d = START;
                        byte_d  = byte_q + 4'd1;
                    end else begin
                        state_d = GAP;
                        gap_d   = '0;
                    end
                end
            end
            GAP: begin
                if (baud_tick) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = START;
                        byte_d  = byte_q + 4'd1;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // txd is registered from next-state values so the line never glitches.
    assign next_byte = frame_byte(byte_d, pix_x_d, pix_y_d, cxs_d, cys_d, dcx_d, dcy_d, max_iter_d);

    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = next_byte[bit_d];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            byte_q     <= 4'd0;
            gap_q      <= '0;
            done_q     <= 1'b0;
            txd_q      <= 1'b1;
            pix_x_q    <= '0;
            pix_y_q    <= '0;
            cxs_q      <= '0;
            cys_q      <= '0;
            dcx_q      <= '0;
            dcy_q      <= '0;
            max_iter_q <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            gap_q      <= gap_d;
            done_q     <= done_d;
            txd_q      <= txd_d;
            pix_x_q    <= pix_x_d;
            pix_y_q    <= pix_y_d;
            cxs_q      <= cxs_d;
            cys_q      <= cys_d;
            dcx_q      <= dcx_d;
            dcy_q      <= dcy_d;
            max_iter_q <= max_iter_d;
        end
    end

    assign txd  = txd_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_mandel_cmd_tx.sv
// Bench for mandel_cmd_tx: a line decoder checks every byte, bit width and spacing
// against a queue of expected bytes filled when each frame is started.
module tb_mandel_cmd_tx;

    localparam int CLK_HZ   = 1000;
    localparam int BAUD     = 100;
    localparam int GAP_BITS = 1;
    localparam int DIV      = 10;
    localparam int BYTE_SPAN = (10 + GAP_BITS) * DIV;
    localparam int LIMIT    = 4000;
`ifdef MANDEL_CMD_TX_CKSUM_EN
    localparam int NBYTES  = 14;
    localparam int FRAME_T = 1530;
`else
    localparam int NBYTES  = 13;
    localparam int FRAME_T = 1420;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  pix_x = '0;
    logic [7:0]  pix_y = '0;
    logic [15:0] cxs = '0, cys = '0, dcx = '0, dcy = '0, max_iter = '0;
    logic        txd, busy, done;

    mandel_cmd_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .GAP_BITS(GAP_BITS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_x(pix_x), .pix_y(pix_y), .cxs(cxs), .cys(cys),
        .dcx(dcx), .dcy(dcy), .max_iter(max_iter),
        .txd(txd), .busy(busy), .done(done)
    );

    typedef struct {
        logic [8:0]       pix_x;
        logic [7:0]       pix_y;
        logic [15:0]      cxs, cys, dcx, dcy, max_iter;
        logic [0:13][7:0] bytes;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        bit         first;
        longint     t0;
    } exp_t;

    vec_t   vecs [3];
    exp_t   exp_q [$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    bit     mon_abort = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic setInputs(input int idx);
        pix_x    = vecs[idx].pix_x;
        pix_y    = vecs[idx].pix_y;
        cxs      = vecs[idx].cxs;
        cys      = vecs[idx].cys;
        dcx      = vecs[idx].dcx;
        dcy      = vecs[idx].dcy;
        max_iter = vecs[idx].max_iter;
    endtask

    // Called at a falling edge; returns at the first falling edge after the capture edge.
    task automatic applyStimulus(input int idx);
        exp_t e;
        setInputs(idx);
        start = 1'b1;
        for (int b = 0; b < NBYTES; b++) begin
            e.data  = vecs[idx].bytes[b];
            e.first = (b == 0);
            e.t0    = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles to frame end; optionally injects an ignored start or chains a new frame.
    task automatic waitFrame(input int inject_at, input int chain_idx);
        int len;
        len = 0;
        while (busy === 1'b1 && len < LIMIT) begin
            if (len == inject_at) begin
                setInputs(1);
                start = 1'b1;
            end else if (len == inject_at + 1) begin
                start = 1'b0;
            end
            len++;
            @(negedge clk);
        end
        checkOutput("busy_len", len, FRAME_T);
        checkOutput("done_pulse", {31'b0, done}, 1);
        if (chain_idx >= 0) begin
            applyStimulus(chain_idx);
            checkOutput("b2b_start", {29'b0, done, busy, txd}, 3'b010);
        end else begin
            @(negedge clk);
            checkOutput("post_frame", {29'b0, done, busy, txd}, 3'b001);
        end
    endtask

    // Line decoder: samples every cycle of every bit so any width error shows as instability.
    logic [9:0] mon_bits;
    bit         mon_stable, mon_aborted;
    longint     mon_t0, last_t0 = 0;
    exp_t       mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (txd === 1'b0 && !mon_abort) begin
                mon_t0      = cyc;
                mon_bits    = '0;
                mon_bits[0] = txd;
                mon_stable  = 1'b1;
                mon_aborted = 1'b0;
                for (int k = 1; k < 100; k++) begin
                    @(negedge clk);
                    if (mon_abort) begin
                        mon_aborted = 1'b1;
                        break;
                    end
                    if (k % 10 == 0) mon_bits[k / 10] = txd;
                    else if (txd !== mon_bits[k / 10]) mon_stable = 1'b0;
                end
                if (!mon_aborted) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_byte: got %0h, expected no byte", mon_bits[8:1]);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("byte", {21'b0, mon_stable, mon_bits},
                                    {21'b0, 1'b1, 1'b1, mon_e.data, 1'b0});
                        if (mon_e.first)
                            checkOutput("start_latency", 32'(mon_t0), 32'(mon_e.t0));
                        else
                            checkOutput("byte_spacing", 32'(mon_t0 - last_t0), BYTE_SPAN);
                    end
                    last_t0 = mon_t0;
                end
            end
        end
    end

    initial begin
        int busy_seen, done_seen;

        vecs[0] = '{pix_x: 9'd509, pix_y: 8'd254, cxs: 16'hE000, cys: 16'hF000,
                    dcx: 16'h0020, dcy: 16'h0020, max_iter: 16'd100,
                    bytes: {8'h01, 8'hFD, 8'hFE, 8'hE0, 8'h00, 8'hF0, 8'h00,
                            8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'h64, 8'h76}};
        vecs[1] = '{pix_x: 9'd0, pix_y: 8'd0, cxs: 16'h1234, cys: 16'hABCD,
                    dcx: 16'h0001, dcy: 16'h8000, max_iter: 16'hFFFF,
                    bytes: {8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD,
                            8'h00, 8'h01, 8'h80, 8'h00, 8'hFF, 8'hFF, 8'hC1}};
        vecs[2] = '{pix_x: 9'd256, pix_y: 8'h5A, cxs: 16'h00FF, cys: 16'hFF00,
                    dcx: 16'h5555, dcy: 16'hAAAA, max_iter: 16'h0001,
                    bytes: {8'h01, 8'h00, 8'h5A, 8'h00, 8'hFF, 8'hFF, 8'h00,
                            8'h55, 8'h55, 8'hAA, 8'hAA, 8'h00, 8'h01, 8'h5A}};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", {29'b0, txd, busy, done}, 3'b100);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(i);
            waitFrame(-1, -1);
            repeat (3) @(negedge clk);
        end

        $display("[TB] start while busy, inputs changed mid-frame");
        applyStimulus(0);
        waitFrame(500, -1);
        busy_seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen++;
        end
        checkOutput("no_second_frame", busy_seen, 0);
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("[TB] start in the done cycle");
        applyStimulus(2);
        waitFrame(-1, 0);
        waitFrame(-1, -1);
        repeat (5) @(negedge clk);

        $display("[TB] reset during byte 5");
        applyStimulus(1);
        repeat (579) @(negedge clk);
        mon_abort = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid_frame", {29'b0, txd, busy, done}, 3'b100);
        exp_q.delete();
        busy_seen = 0;
        done_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1 || txd !== 1'b1) busy_seen++;
        end
        checkOutput("rst_no_done", done_seen, 0);
        checkOutput("rst_stays_idle", busy_seen, 0);
        mon_abort = 1'b0;
        applyStimulus(2);
        waitFrame(-1, -1);

        repeat (5) @(negedge clk);
        checkOutput("queue_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
